// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXIS frame generator and its matching checker:
// LFSR step, lane pattern and FSM state encoding.
package axis_pkg;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_e;

  // Right-shifting Galois form, taps 32,22,2,1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  function automatic logic [31:0] lane_word(input logic [31:0] base, input int k);
    return base + k[31:0];
  endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI-Stream link bundle with source (master) and sink (slave) views.
interface ifc_axis #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen_lfsr.sv
// 32-bit Galois LFSR with load and step enable; the checker instantiates the
// same module so both ends walk an identical sequence.
module axis_lfsr32
  import axis_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] value
);
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = SEED;
    else if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;
endmodule

// File: rtl/axis_frame_gen.sv
// AXIS frame source: programmable length/count/gap frames whose lanes carry
// lfsr+k, with optional pseudo-random tvalid bubbles.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | presenting beats of the current frame
// GAP   | counting idle cycles before the next frame
module axis_frame_gen
  import axis_pkg::*;
#(
  parameter int          DATA_WIDTH = 128,
  parameter int          LEN_WIDTH  = 16,
  parameter int          CNT_WIDTH  = 32,
  parameter int          GAP_WIDTH  = 8,
  parameter logic [31:0] SEED       = 32'hACE1_2024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [CNT_WIDTH-1:0] num_frames,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  input  logic                 bubble_en,
  ifc_axis.master              m_axis_ifc,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic [CNT_WIDTH-1:0] frames_sent
);
  localparam int LANES = DATA_WIDTH / 32;

  gen_state_e            state_q, state_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  busy_q, busy_d, done_q, done_d, err_len_q, err_len_d;
  logic [CNT_WIDTH-1:0]  frames_sent_q, frames_sent_d, num_q, num_d;
  logic [LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d, len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                  bub_q, bub_d, stop_q, stop_d, guard_q, guard_d;

  logic                  hs, load_beat, lfsr_load, lfsr_step;
  logic [31:0]           lfsr_val, beat_base;
  logic [DATA_WIDTH-1:0] pattern;

  axis_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  assign hs = tvalid_q & m_axis_ifc.tready;

  always_comb begin
    pattern = '0;
    for (int k = 0; k < LANES; k++) pattern[32*k +: 32] = lane_word(beat_base, k);
  end

  always_comb begin
    state_d       = state_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_len_d     = 1'b0;
    frames_sent_d = frames_sent_q;
    beat_idx_d    = beat_idx_q;
    len_d         = len_q;
    num_d         = num_q;
    gap_d         = gap_q;
    bub_d         = bub_q;
    stop_d        = stop_q | stop;
    gap_cnt_d     = gap_cnt_q;
    guard_d       = guard_q;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;
    load_beat     = 1'b0;
    beat_base     = lfsr_val;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            err_len_d = 1'b1;
          end else begin
            len_d         = frame_len;
            num_d         = num_frames;
            gap_d         = gap_cycles;
            bub_d         = bubble_en;
            stop_d        = stop;
            lfsr_load     = 1'b1;
            frames_sent_d = '0;
            beat_idx_d    = '0;
            guard_d       = 1'b0;
            busy_d        = 1'b1;
            state_d       = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (hs) begin
          lfsr_step = 1'b1;
          beat_base = lfsr_next(lfsr_val);
          if (tlast_q) begin
            frames_sent_d = frames_sent_q + CNT_WIDTH'(1);
            beat_idx_d    = '0;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            if (((num_q != '0) && (frames_sent_d == num_q)) || stop_d) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (gap_q == '0) begin
              load_beat = 1'b1;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = ST_GAP;
            end
          end else begin
            beat_idx_d = beat_idx_q + LEN_WIDTH'(1);
            load_beat  = 1'b1;
          end
        end else if (!tvalid_q) begin
          load_beat = 1'b1;
        end
      end
      ST_GAP: begin
        if (stop_d) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          // Load on the last gap cycle so the idle span is exactly gap_cycles.
          load_beat = 1'b1;
          state_d   = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_beat) begin
      if (bub_q && beat_base[31] && !guard_q) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        guard_d  = 1'b1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = pattern;
        tlast_d  = (beat_idx_d == len_q - LEN_WIDTH'(1));
        guard_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_len_q     <= 1'b0;
      frames_sent_q <= '0;
      beat_idx_q    <= '0;
      len_q         <= '0;
      num_q         <= '0;
      gap_q         <= '0;
      bub_q         <= 1'b0;
      stop_q        <= 1'b0;
      gap_cnt_q     <= '0;
      guard_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_len_q     <= err_len_d;
      frames_sent_q <= frames_sent_d;
      beat_idx_q    <= beat_idx_d;
      len_q         <= len_d;
      num_q         <= num_d;
      gap_q         <= gap_d;
      bub_q         <= bub_d;
      stop_q        <= stop_d;
      gap_cnt_q     <= gap_cnt_d;
      guard_q       <= guard_d;
    end
  end

  assign m_axis_ifc.tdata  = tdata_q;
  assign m_axis_ifc.tvalid = tvalid_q;
  assign m_axis_ifc.tlast  = tlast_q;
  assign m_axis_ifc.tkeep  = '1;
  assign m_axis_ifc.tid    = '0;
  assign m_axis_ifc.tdest  = '0;
  assign m_axis_ifc.tuser  = '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_len_q;
  assign frames_sent = frames_sent_q;
endmodule
